// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, opcode field position and FSM encoding for the instruction-fetch sequencer.
package fetch_sequencer_pkg;
  localparam int IW       = 16;
  localparam int AW       = 4;
  localparam int IQ_DEPTH = 4;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam logic [OP_MSB-OP_LSB:0] HALT_OP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  function automatic logic is_halt(input logic [IW-1:0] word);
    return word[OP_MSB:OP_LSB] == HALT_OP;
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// Control, memory and issue-queue signals of the fetch sequencer, bundled as one interface.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic          start;
  logic [AW:0]   prog_len;
  logic [AW-1:0] pc;
  logic          fetch_en;
  logic [IW-1:0] mem_instr;
  logic          iq_valid;
  logic [IW-1:0] iq_instr;
  logic [AW-1:0] iq_pc;
  logic          iq_ready;
  logic          busy;
  logic          done;
  logic [7:0]    stall_cnt;

  modport master (
    input  start, prog_len, mem_instr, iq_ready,
    output pc, fetch_en, iq_valid, iq_instr, iq_pc, busy, done, stall_cnt
  );

  modport slave (
    output start, prog_len, mem_instr, iq_ready,
    input  pc, fetch_en, iq_valid, iq_instr, iq_pc, busy, done, stall_cnt
  );
endinterface

// File: rtl/fetch_sequencer_fifo.sv
// Power-of-two synchronous FIFO with occupancy count; push and pop together are legal even when full.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [W-1:0]          wdata_i,
  input  logic                  pop_i,
  output logic [W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push_i && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // When full, a simultaneous pop frees exactly the slot being overwritten.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the PC, absorbs one-cycle memory latency and queues words for issue.
//   state   | meaning
//   S_IDLE  | after reset, waiting for start
//   S_FETCH | issuing reads while queue credit and program length allow
//   S_DRAIN | fetch ended (length or HALT), waiting for queue and return path to empty
//   S_DONE  | run complete, done held high until next start
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic              clk1,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [AW:0] LEN_MIN = (AW+1)'(1);

  seq_state_e    state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] req_pc_q;
  logic [AW:0]   fetched_q;
  logic [AW:0]   prog_len_q;
  logic          inflight_q;
  logic [7:0]    stall_cnt_q;

  logic [CW-1:0]    occ;
  logic             occ_empty;
  logic [AW+IW-1:0] head;
  logic             credit_ok;
  logic             len_left;
  logic             fetch_en;
  logic             ret_halt;
  logic             push;
  logic             pop;
  logic             start_ok;

  // A read in flight already owns a queue slot, so it counts against credit.
  assign credit_ok = ({1'b0, occ} + {{CW{1'b0}}, inflight_q}) < DEPTH_C;
  assign len_left  = fetched_q < prog_len_q;
  assign fetch_en  = (state_q == S_FETCH) && len_left && credit_ok;
  assign ret_halt  = inflight_q && is_halt(bus.mem_instr);
  assign push      = inflight_q && !ret_halt;
  assign pop       = !occ_empty && bus.iq_ready;
  assign start_ok  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  fetch_fifo #(
    .W     (AW + IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk1),
    .rst_n_i (rst_n),
    .flush_i (start_ok),
    .push_i  (push),
    .wdata_i ({req_pc_q, bus.mem_instr}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (occ),
    .empty_o (occ_empty)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      req_pc_q    <= '0;
      fetched_q   <= '0;
      prog_len_q  <= '0;
      inflight_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      // A HALT returning now cancels the read issued in the same cycle.
      inflight_q <= fetch_en && !ret_halt;
      if (fetch_en) req_pc_q <= pc_q;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            fetched_q   <= '0;
            stall_cnt_q <= '0;
            prog_len_q  <= (bus.prog_len == '0) ? LEN_MIN : bus.prog_len;
          end
        end
        S_FETCH: begin
          if (fetch_en) begin
            pc_q      <= pc_q + 1'b1;
            fetched_q <= fetched_q + 1'b1;
          end else if (len_left && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
          if (ret_halt || !len_left) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (occ_empty && !inflight_q) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.fetch_en  = fetch_en;
  assign bus.iq_valid  = !occ_empty;
  assign bus.iq_instr  = occ_empty ? '0 : head[IW-1:0];
  assign bus.iq_pc     = occ_empty ? '0 : head[AW+IW-1:IW];
  assign bus.busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory model, scoreboard of expected {pc, instr} and assertion checks.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk1 = 1'b0;
  logic rst_n;

  fetch_sequencer_if bus();

  fetch_sequencer #(.DEPTH(4)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  // Registered-read memory; returns a HALT-looking filler when no read was issued.
  logic [IW-1:0] mem [16];
  always @(posedge clk1) begin
    if (bus.fetch_en) bus.mem_instr <= mem[bus.pc];
    else              bus.mem_instr <= 16'hFBAD;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cyc0    = 0;
  int n_deliv = 0;
  int exp_deliv = 0;
  int first_rel = 0;
  int last_rel  = 0;
  int rel;
  logic [AW-1:0]    last_pc;
  logic [AW+IW-1:0] sb [$];
  logic [AW+IW-1:0] exp_e;
  logic [AW+IW-1:0] head_e;

  always @(posedge clk1) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (rst_n && bus.iq_valid && bus.iq_ready) begin
      if (sb.size() > 0) begin
        exp_e = sb.pop_front();
        check("iq_pc", 32'(bus.iq_pc), 32'(exp_e[AW+IW-1:IW]));
        check("iq_instr", 32'(bus.iq_instr), 32'(exp_e[IW-1:0]));
      end
      if (n_deliv == 0) first_rel = cyc - cyc0 + 1;
      last_rel = cyc - cyc0 + 1;
      last_pc  = bus.iq_pc;
      n_deliv++;
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic load_prog(input int len, input int halt_at);
    int eff;
    eff = (len == 0) ? 1 : len;
    sb.delete();
    n_deliv   = 0;
    first_rel = 0;
    last_rel  = 0;
    for (int i = 0; i < 16; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    if (halt_at >= 0) mem[halt_at] = {HALT_OP, 12'($urandom)};
    for (int i = 0; i < eff; i++) begin
      if (i == halt_at) break;
      sb.push_back({4'(i), mem[i]});
    end
    exp_deliv = sb.size();
  endtask

  task automatic start_run(input int len);
    bus.prog_len = 5'(len);
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic wait_done(output int r);
    for (int i = 0; i < 80 && !bus.done; i++) tick();
    check("done_reached", 32'(bus.done), 32'd1);
    r = cyc - cyc0 + 1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},        32'(bus.pc),        32'd0);
    check({tag, "_fetch_en"},  32'(bus.fetch_en),  32'd0);
    check({tag, "_iq_valid"},  32'(bus.iq_valid),  32'd0);
    check({tag, "_iq_instr"},  32'(bus.iq_instr),  32'd0);
    check({tag, "_iq_pc"},     32'(bus.iq_pc),     32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
  endtask

  task automatic check_run_end(input string tag);
    check({tag, "_delivered"}, 32'(n_deliv),   32'(exp_deliv));
    check({tag, "_sb_empty"},  32'(sb.size()), 32'd0);
    check({tag, "_busy"},      32'(bus.busy),  32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.prog_len = '0;
    bus.iq_ready = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Straight run, six instructions, issue always ready
    load_prog(6, -1);
    start_run(6);
    check("t1_fetch_en_first", 32'(bus.fetch_en), 32'd1);
    check("t1_pc_first",       32'(bus.pc),       32'd0);
    check("t1_busy",           32'(bus.busy),     32'd1);
    wait_done(rel);
    check("t1_done_cycle",  32'(rel),           32'd10);
    check("t1_first_pop",   32'(first_rel),     32'd3);
    check("t1_last_pop",    32'(last_rel),      32'd8);
    check("t1_stall_cnt",   32'(bus.stall_cnt), 32'd0);
    check_run_end("t1");

    // Back-pressure: issue stalls for the first ten cycles
    load_prog(8, -1);
    bus.iq_ready = 1'b0;
    start_run(8);
    repeat (9) tick();
    head_e = sb[0];
    check("t2_pc_hold",      32'(bus.pc),        32'd4);
    check("t2_stall_mid",    32'(bus.stall_cnt), 32'd5);
    check("t2_head_pc",      32'(bus.iq_pc),     32'(head_e[AW+IW-1:IW]));
    check("t2_head_instr",   32'(bus.iq_instr),  32'(head_e[IW-1:0]));
    tick();
    bus.iq_ready = 1'b1;
    check("t2_full_no_fetch", 32'(bus.fetch_en), 32'd0);
    wait_done(rel);
    check("t2_stall_cnt", 32'(bus.stall_cnt), 32'd7);
    check_run_end("t2");

    // HALT at address 3 ends the program early
    load_prog(10, 3);
    start_run(10);
    wait_done(rel);
    check("t3_last_pc", 32'(last_pc), 32'd2);
    check_run_end("t3");

    // Full 16-word program, PC register wraps to zero only after the final fetch
    load_prog(16, -1);
    start_run(16);
    wait_done(rel);
    check("t4_last_pc", 32'(last_pc), 32'd15);
    check("t4_pc_after", 32'(bus.pc), 32'd0);
    check_run_end("t4");

    // Reset mid-fetch with two entries queued
    load_prog(8, -1);
    bus.iq_ready = 1'b0;
    start_run(8);
    repeat (3) tick();
    check("t5_queued_valid", 32'(bus.iq_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("t5_midrst");
    tick();
    rst_n = 1'b1;
    bus.iq_ready = 1'b1;
    load_prog(3, -1);
    start_run(3);
    check("t5_restart_pc",    32'(bus.pc),       32'd0);
    check("t5_restart_fetch", 32'(bus.fetch_en), 32'd1);
    wait_done(rel);
    check_run_end("t5");

    // start during DRAIN is ignored; a start after DONE reruns and clears stall_cnt
    load_prog(8, -1);
    bus.iq_ready = 1'b0;
    start_run(8);
    repeat (10) tick();
    bus.iq_ready = 1'b1;
    repeat (5) tick();
    bus.iq_ready = 1'b0;
    tick();
    bus.prog_len = 5'd2;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t6_drain_pc",    32'(bus.pc),       32'd8);
    check("t6_drain_fetch", 32'(bus.fetch_en), 32'd0);
    check("t6_drain_busy",  32'(bus.busy),     32'd1);
    bus.iq_ready = 1'b1;
    wait_done(rel);
    check("t6_stall_cnt", 32'(bus.stall_cnt), 32'd7);
    check_run_end("t6a");
    load_prog(2, -1);
    start_run(2);
    check("t6_rerun_stall", 32'(bus.stall_cnt), 32'd0);
    check("t6_rerun_pc",    32'(bus.pc),        32'd0);
    check("t6_rerun_done",  32'(bus.done),      32'd0);
    wait_done(rel);
    check_run_end("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller between the 16-entry, 16-bit instruction memory and the Tomasulo issue stage. Drives the 4-bit PC, absorbs the memory's one-cycle registered read latency, buffers fetched words in a small FIFO, and hands them to issue through a valid/ready handshake. Fetch stops at the program length or on a HALT opcode, then the FIFO drains and `done` is raised.

## Interface
- `DEPTH`, 4, instruction-queue entries (power of two, at least 2)
- `IW`, 16, instruction width
- `AW`, 4, PC width
- `HALT_OP`, 4'b1111, opcode in `instr[15:12]` that terminates fetch
- `clk1`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; accepted only in IDLE or DONE
- `prog_len`  in  AW+1  instruction count (1..16), sampled at `start`
- `pc`  out  AW  address to instruction memory
- `fetch_en`  out  1  a read is issued at `pc` this cycle
- `mem_instr`  in  IW  memory data, valid one cycle after `fetch_en`
- `iq_valid`  out  1  queue head is valid
- `iq_instr`  out  IW  queue head instruction
- `iq_pc`  out  AW  PC of the queue head
- `iq_ready`  in  1  issue stage accepts the head this cycle
- `busy`  out  1  state is FETCH or DRAIN
- `done`  out  1  level, high in DONE
- `stall_cnt`  out  8  cycles with `fetch_en` low in FETCH for lack of credit; saturates at 255

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
  - IDLE/DONE + `start`: go to FETCH; `pc`=0, `fetched`=0, queue flushed, `stall_cnt`=0, `prog_len` latched.
  - Latched `prog_len`=0 is treated as 1.
- FETCH:
  - `fetch_en`=1 when `occupancy + inflight < DEPTH`, where `inflight` is 0 or 1. Each `fetch_en` cycle increments `pc` and `fetched`.
  - With `fetch_en`=0, `pc` holds and `stall_cnt` increments.
- Return path: a request issued in cycle t writes `mem_instr` and its PC into the queue at t+1, unless the request has been cancelled.
- HALT:
  - A returned word with opcode `HALT_OP` is not enqueued.
  - The request issued in the same cycle the HALT returns is cancelled.
  - State moves to DRAIN.
- Length end: when `fetched` reaches `prog_len`, `fetch_en` drops and state moves to DRAIN. The last in-flight word is still enqueued, or dropped if it is HALT.
- DRAIN: no fetch. Move to DONE when the queue is empty and `inflight`=0.
- Queue: FIFO of {PC, instr}. A pop happens when `iq_valid && iq_ready`.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - The credit rule guarantees no push is ever made to a full queue.
- `pc` never wraps within a run. `prog_len`=16 ends with the last fetch at PC 15. The 4-bit `pc` register reads 0 after that increment.
- `start` in FETCH/DRAIN is ignored.

## Timing
- Reset values: `pc`=0, `fetch_en`=0, `iq_valid`=0, `iq_instr`=0, `iq_pc`=0, `busy`=0, `done`=0, `stall_cnt`=0. State is IDLE, queue empty, `inflight`=0.
- Reset asserted mid-run clears everything immediately. Any memory response in flight is discarded.
- `start` at edge n: FETCH and `fetch_en`=1 with `pc`=0 in cycle n+1. The word arrives at n+2 and `iq_valid`=1 in cycle n+3 (queue registered).
- Steady state with `iq_ready` held high: one instruction per cycle.
- `done` rises the cycle after the final pop when nothing is in flight.
- `iq_instr`/`iq_pc` stay stable while `iq_valid && !iq_ready`.

## Structure
- Shared package holds `IW`, `AW`, `HALT_OP`, opcode-field slice constants, and the state enum.
- One sub-module, `fetch_fifo`: parameterized synchronous FIFO with count output, used for the queue.
- Credit/`inflight` logic and the FSM live in the top.

## Test plan
- `prog_len`=6, `iq_ready`=1, no HALT: PCs 0..5 appear on `iq_pc` in consecutive cycles starting at start+3. `done` at start+10. `stall_cnt`=0.
- `iq_ready`=0 for 10 cycles after start, `prog_len`=8: exactly 4 entries queued, `pc` holds at 4, `stall_cnt`=7. On release, all 8 delivered in order.
- HALT word at address 3, `prog_len`=10: only PCs 0..2 delivered. PC-4 data never enqueued. DONE reached.
- `prog_len`=16, all non-HALT: PC 15 delivered last, no wrap to 0.
- `rst_n` pulsed low mid-FETCH with 2 queued: outputs return to reset values at once. A new `start` fetches from PC 0.
- `start` pulsed during DRAIN: ignored. After DONE, a second `start` reruns and clears `stall_cnt`.
